// File: rtl/alu_issue.sv
// Request/response sequencer for the shared combinational ALU: decodes one RV32I
// OP/OP-IMM instruction, drives the ALU for one cycle, then returns result and flags.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  input  logic        alu_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_rd,
  output logic [3:0]  rsp_flags,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;

  state_e      state_q, state_d;
  logic [31:0] aluSrc1_q, aluSrc1_d;
  logic [31:0] aluSrc2_q, aluSrc2_d;
  logic [3:0]  aluAluc_q, aluAluc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  flags_q, flags_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7Zero;
  logic        f7Alt;
  logic        decLegal;
  logic [3:0]  decAluc;
  logic [31:0] decSrc2;

  assign opcode = req_instr[6:0];
  assign funct3 = req_instr[14:12];
  assign funct7 = req_instr[31:25];
  assign f7Zero = (funct7 == 7'b0000000);
  assign f7Alt  = (funct7 == 7'b0100000);

  // Shifts take only a 5-bit amount, from rs2 for OP and from the immediate for OP-IMM.
  always_comb begin
    decLegal = 1'b0;
    decAluc  = AluAdd;
    decSrc2  = req_rs2;
    if (opcode == OpcOp) begin
      case (funct3)
        3'b000: begin decLegal = f7Zero | f7Alt; decAluc = f7Alt ? AluSub : AluAdd; end
        3'b001: begin decLegal = f7Zero; decAluc = AluSll; decSrc2 = {27'b0, req_rs2[4:0]}; end
        3'b010: begin decLegal = f7Zero; decAluc = AluSlt;  end
        3'b011: begin decLegal = f7Zero; decAluc = AluSltu; end
        3'b100: begin decLegal = f7Zero; decAluc = AluXor;  end
        3'b101: begin
          decLegal = f7Zero | f7Alt;
          decAluc  = f7Alt ? AluSra : AluSrl;
          decSrc2  = {27'b0, req_rs2[4:0]};
        end
        3'b110: begin decLegal = f7Zero; decAluc = AluOr;  end
        default: begin decLegal = f7Zero; decAluc = AluAnd; end
      endcase
    end else if (opcode == OpcOpImm) begin
      decSrc2 = {{20{req_instr[31]}}, req_instr[31:20]};
      case (funct3)
        3'b000: begin decLegal = 1'b1; decAluc = AluAdd;  end
        3'b001: begin decLegal = f7Zero; decAluc = AluSll; decSrc2 = {27'b0, req_instr[24:20]}; end
        3'b010: begin decLegal = 1'b1; decAluc = AluSlt;  end
        3'b011: begin decLegal = 1'b1; decAluc = AluSltu; end
        3'b100: begin decLegal = 1'b1; decAluc = AluXor;  end
        3'b101: begin
          decLegal = f7Zero | f7Alt;
          decAluc  = f7Alt ? AluSra : AluSrl;
          decSrc2  = {27'b0, req_instr[24:20]};
        end
        3'b110: begin decLegal = 1'b1; decAluc = AluOr;  end
        default: begin decLegal = 1'b1; decAluc = AluAnd; end
      endcase
    end
  end

  // Illegal requests skip EXEC and leave the ALU operands untouched.
  always_comb begin
    state_d   = state_q;
    aluSrc1_d = aluSrc1_q;
    aluSrc2_d = aluSrc2_q;
    aluAluc_d = aluAluc_q;
    result_d  = result_q;
    rd_d      = rd_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d = req_instr[11:7];
          if (decLegal) begin
            aluSrc1_d = req_rs1;
            aluSrc2_d = decSrc2;
            aluAluc_d = decAluc;
            state_d   = EXEC;
          end else begin
            result_d  = 32'b0;
            flags_d   = 4'b0;
            illegal_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      EXEC: begin
        result_d  = alu_out;
        flags_d   = {alu_sign, alu_overflow, alu_cout, alu_zero};
        illegal_d = 1'b0;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aluSrc1_q <= 32'b0;
      aluSrc2_q <= 32'b0;
      aluAluc_q <= 4'b0;
      result_q  <= 32'b0;
      rd_q      <= 5'b0;
      flags_q   <= 4'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aluSrc1_q <= aluSrc1_d;
      aluSrc2_q <= aluSrc2_d;
      aluAluc_q <= aluAluc_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign alu_src1    = aluSrc1_q;
  assign alu_src2    = aluSrc2_q;
  assign alu_aluc    = aluAluc_q;
  assign rsp_result  = result_q;
  assign rsp_rd      = rd_q;
  assign rsp_flags   = flags_q;
  assign rsp_illegal = illegal_q;

endmodule
